// File: rtl/rv32_e_muldiv_unit_if.sv
// Request/response bundle for the RV32M execute-stage unit.
// slave = the unit, master = the issuing pipeline and result consumer.
`ifndef ALU_CONTROL_WIDTH
`define ALU_CONTROL_WIDTH 5
`define ALU_ADD    5'd0
`define ALU_MUL    5'd10
`define ALU_MULH   5'd11
`define ALU_MULHSU 5'd12
`define ALU_MULHU  5'd13
`define ALU_DIV    5'd14
`define ALU_DIVU   5'd15
`define ALU_REM    5'd16
`define ALU_REMU   5'd17
`endif

interface rv32_e_muldiv_unit_if #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 5
);
  logic                          flush_i;
  logic                          valid_i;
  logic                          ready_o;
  logic [`ALU_CONTROL_WIDTH-1:0] alu_control_i;
  logic [XLEN-1:0]               src_a_i;
  logic [XLEN-1:0]               src_b_i;
  logic [TAG_WIDTH-1:0]          rd_i;
  logic                          valid_o;
  logic                          ready_i;
  logic [XLEN-1:0]               result_o;
  logic [TAG_WIDTH-1:0]          rd_o;
  logic                          busy_o;

  modport master (
    output flush_i, valid_i, alu_control_i, src_a_i, src_b_i, rd_i, ready_i,
    input  ready_o, valid_o, result_o, rd_o, busy_o
  );
  modport slave (
    input  flush_i, valid_i, alu_control_i, src_a_i, src_b_i, rd_i, ready_i,
    output ready_o, valid_o, result_o, rd_o, busy_o
  );
endinterface

// File: rtl/rv32_e_muldiv_unit.sv
// Multi-cycle RV32M unit: 2-cycle multiply, 32-step restoring divide,
// divide-by-zero and signed overflow resolved at accept.
`ifndef ALU_CONTROL_WIDTH
`define ALU_CONTROL_WIDTH 5
`define ALU_ADD    5'd0
`define ALU_MUL    5'd10
`define ALU_MULH   5'd11
`define ALU_MULHSU 5'd12
`define ALU_MULHU  5'd13
`define ALU_DIV    5'd14
`define ALU_DIVU   5'd15
`define ALU_REM    5'd16
`define ALU_REMU   5'd17
`endif

module rv32_e_muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 5
) (
  input logic clk_i,
  input logic rst_i,
  rv32_e_muldiv_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state, state_n;

  // op encoding: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu
  logic [2:0]           op_d, op_q;
  logic                 legal, accept;
  logic [XLEN-1:0]      acc, dvs, rem;
  logic [TAG_WIDTH-1:0] rd_q;
  logic [4:0]           cnt;
  logic                 q_neg, r_neg;

  always_comb begin
    legal = 1'b1;
    op_d  = 3'd0;
    case (bus.alu_control_i)
      `ALU_MUL:    op_d = 3'd0;
      `ALU_MULH:   op_d = 3'd1;
      `ALU_MULHSU: op_d = 3'd2;
      `ALU_MULHU:  op_d = 3'd3;
      `ALU_DIV:    op_d = 3'd4;
      `ALU_DIVU:   op_d = 3'd5;
      `ALU_REM:    op_d = 3'd6;
      `ALU_REMU:   op_d = 3'd7;
      default:     legal = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && bus.valid_i && !bus.flush_i && legal;

  logic            sgn_div, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b;
  assign sgn_div  = !op_d[0];
  assign div_zero = (bus.src_b_i == '0);
  assign div_ovf  = sgn_div && (bus.src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src_b_i == '1);
  assign abs_a    = (sgn_div && bus.src_a_i[XLEN-1]) ? -bus.src_a_i : bus.src_a_i;
  assign abs_b    = (sgn_div && bus.src_b_i[XLEN-1]) ? -bus.src_b_i : bus.src_b_i;

  // Multiply operands live in acc/dvs; MULHU zero-extends a, only MUL/MULH sign-extend b.
  logic signed [XLEN:0]     ae, be;
  logic signed [2*XLEN-1:0] prod;
  assign ae   = {(op_q != 3'd3) & acc[XLEN-1], acc};
  assign be   = {!op_q[1] & dvs[XLEN-1], dvs};
  assign prod = $signed({{(XLEN-1){ae[XLEN]}}, ae}) * $signed({{(XLEN-1){be[XLEN]}}, be});

  logic [XLEN:0] rem_sh, diff;
  logic          ge;
  assign rem_sh = {rem, acc[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign ge     = !diff[XLEN];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = !op_d[2] ? MUL : ((div_zero || div_ovf) ? FIX : DIV);
      MUL:     state_n = DONE;
      DIV:     if (cnt == '0) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    if (bus.ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.flush_i && state != IDLE) state_n = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q <= '0; acc <= '0; dvs <= '0; rem <= '0; rd_q <= '0; cnt <= '0;
      q_neg <= 1'b0; r_neg <= 1'b0;
      bus.result_o <= '0; bus.rd_o <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q  <= op_d;
          rd_q  <= bus.rd_i;
          cnt   <= 5'd31;
          q_neg <= 1'b0;
          r_neg <= 1'b0;
          if (!op_d[2]) begin
            acc <= bus.src_a_i;
            dvs <= bus.src_b_i;
          end else if (div_zero) begin
            acc <= '1;
            rem <= bus.src_a_i;
          end else if (div_ovf) begin
            acc <= {1'b1, {(XLEN-1){1'b0}}};
            rem <= '0;
          end else begin
            acc   <= abs_a;
            dvs   <= abs_b;
            rem   <= '0;
            q_neg <= sgn_div && (bus.src_a_i[XLEN-1] ^ bus.src_b_i[XLEN-1]);
            r_neg <= sgn_div && bus.src_a_i[XLEN-1];
          end
        end
        MUL: if (!bus.flush_i) begin
          bus.result_o <= (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          bus.rd_o     <= rd_q;
        end
        DIV: begin
          rem <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
          acc <= {acc[XLEN-2:0], ge};
          cnt <= cnt - 5'd1;
        end
        FIX: if (!bus.flush_i) begin
          bus.result_o <= op_q[1] ? (r_neg ? -rem : rem) : (q_neg ? -acc : acc);
          bus.rd_o     <= rd_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o = (state == IDLE);
  assign bus.busy_o  = (state != IDLE);
  assign bus.valid_o = (state == DONE);
endmodule

// File: tb/tb_rv32_e_muldiv_unit.sv
// Directed bench for rv32_e_muldiv_unit: expected results go into a scoreboard
// queue at issue; a monitor pops and compares on each valid/ready handshake.
`ifndef ALU_CONTROL_WIDTH
`define ALU_CONTROL_WIDTH 5
`define ALU_ADD    5'd0
`define ALU_MUL    5'd10
`define ALU_MULH   5'd11
`define ALU_MULHSU 5'd12
`define ALU_MULHU  5'd13
`define ALU_DIV    5'd14
`define ALU_DIVU   5'd15
`define ALU_REM    5'd16
`define ALU_REMU   5'd17
`endif

module tb_rv32_e_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  rv32_e_muldiv_unit_if #(.XLEN(32), .TAG_WIDTH(5)) bus ();

  rv32_e_muldiv_unit #(.XLEN(32), .TAG_WIDTH(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    string       name;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst === 1'b0 && bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_result: got %h rd %0d expected no result", bus.result_o, bus.rd_o);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, bus.result_o, e.res);
        chk({e.name, "_rd"}, 32'(bus.rd_o), 32'(e.rd));
      end
    end
  end

  task automatic send(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    @(negedge clk);
    chk("ready_before_send", 32'(bus.ready_o), 32'd1);
    bus.valid_i = 1'b1; bus.alu_control_i = ctl;
    bus.src_a_i = a; bus.src_b_i = b; bus.rd_i = rd;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
  endtask

  // Returns at the negedge of the cycle in which valid_o is first seen.
  task automatic wait_valid(input int lat, input string nm);
    bit busy_ok = 1'b1;
    int n = 1;
    forever begin
      @(negedge clk);
      if (!bus.busy_o) busy_ok = 1'b0;
      if (bus.valid_o) break;
      if (n >= 200) break;
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    chk({nm, "_busy"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic run(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input int lat,
                     input string nm);
    send(ctl, a, b, rd);
    sb.push_back('{exp, rd, nm});
    wait_valid(lat, nm);
    @(negedge clk);
    chk({nm, "_idle_after"}, 32'(bus.ready_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    bus.flush_i = 1'b0; bus.valid_i = 1'b0; bus.ready_i = 1'b1;
    bus.alu_control_i = `ALU_ADD; bus.src_a_i = '0; bus.src_b_i = '0; bus.rd_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_result", bus.result_o, 32'd0);
    chk("rst_rd", 32'(bus.rd_o), 32'd0);
    rst = 1'b0;

    run(`ALU_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000001, 2, "mul_m1");
    run(`ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000, 2, "mulh_m1");
    run(`ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, 2, "mulhu_m1");
    run(`ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 2, "mulhsu_m1");

    run(`ALU_DIV,  32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 34, "div_neg7_2");
    run(`ALU_REM,  32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 34, "rem_neg7_2");
    run(`ALU_DIVU, 32'd100,      32'd7, 5'd7, 32'd14,       34, "divu_100_7");
    run(`ALU_REMU, 32'd100,      32'd7, 5'd8, 32'd2,        34, "remu_100_7");

    run(`ALU_DIV, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 2, "div_by0");
    run(`ALU_REM, 32'd5,        32'd0,        5'd10, 32'd5,        2, "rem_by0");
    run(`ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 2, "div_ovf");
    run(`ALU_REM, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        2, "rem_ovf");

    // Backpressure: hold the result three cycles.
    bus.ready_i = 1'b0;
    send(`ALU_DIVU, 32'd100, 32'd7, 5'd13);
    sb.push_back('{32'd14, 5'd13, "bp_divu"});
    wait_valid(34, "bp_divu");
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", 32'(bus.valid_o), 32'd1);
      chk("bp_hold_result", bus.result_o, 32'd14);
      chk("bp_hold_rd", 32'(bus.rd_o), 32'd13);
      @(negedge clk);
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    chk("bp_idle_after", 32'(bus.ready_o), 32'd1);

    // Flush at cycle 10 of a divide.
    send(`ALU_DIV, 32'd100, 32'd7, 5'd14);
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_ready_c11", 32'(bus.ready_o), 32'd1);
    chk("flush_valid_c11", 32'(bus.valid_o), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o) seen = 1'b1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    run(`ALU_MUL, 32'd3, 32'd4, 5'd15, 32'd12, 2, "mul_after_flush");

    // Illegal op is ignored.
    @(negedge clk);
    bus.valid_i = 1'b1; bus.alu_control_i = `ALU_ADD;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    @(negedge clk);
    chk("illegal_ready", 32'(bus.ready_o), 32'd1);
    chk("illegal_busy", 32'(bus.busy_o), 32'd0);

    // Asynchronous reset mid-division, checked before any clock edge.
    send(`ALU_DIVU, 32'd100, 32'd7, 5'd16);
    repeat (5) @(negedge clk);
    chk("pre_arst_busy", 32'(bus.busy_o), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.valid_o), 32'd0);
    chk("arst_busy", 32'(bus.busy_o), 32'd0);
    chk("arst_ready", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    run(`ALU_DIVU, 32'd100, 32'd7, 5'd17, 32'd14, 34, "divu_after_rst");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/rv32_e_muldiv_unit.md
Name: rv32_e_muldiv_unit

Overview:
Execute-stage multi-cycle RV32M unit. It consumes the ALU control codes for MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, as produced by the decode-stage ALU decoder, together with both operands. It returns a 32-bit result through a valid/ready handshake. The pipeline stalls on ready_o/valid_o; flush_i kills an in-flight op on redirect or trap.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
TAG_WIDTH, 5, width of the destination-register tag carried alongside the op.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  reset, asynchronous, active-high.
flush_i  input  1  abort any in-flight op; no result produced.
valid_i  input  1  request valid.
ready_o  output  1  unit can accept a request; high only in IDLE.
alu_control_i  input  `ALU_CONTROL_WIDTH  operation code from defines_header.svh.
src_a_i  input  XLEN  rs1 operand / dividend.
src_b_i  input  XLEN  rs2 operand / divisor.
rd_i  input  TAG_WIDTH  destination tag.
valid_o  output  1  result valid.
ready_i  input  1  consumer accepts result.
result_o  output  XLEN  result.
rd_o  output  TAG_WIDTH  tag of the result.
busy_o  output  1  state != IDLE.

Behaviour:
- States: IDLE, MUL, DIV, FIX, DONE.
- Reset: state=IDLE; valid_o=0; result_o=0; rd_o=0; busy_o=0; ready_o=1.
- Accept: at a rising edge with valid_i && ready_o && !flush_i && alu_control_i in {MUL..REMU}, capture operands, op and rd_i.
- Illegal op: valid_i with any other code is ignored; the unit stays IDLE.
- Call the accept edge cycle 0.
- Multiply path:
  - IDLE->MUL.
  - In cycle 1, form a 33x33 signed product. Sign-extend a for MUL/MULH/MULHSU, zero-extend a for MULHU. Sign-extend b for MUL/MULH only.
  - Register the low 32 bits (MUL) or bits [63:32] (MULH/MULHSU/MULHU). MUL->DONE.
  - valid_o rises in cycle 2 (latency 2).
- Divide path, special cases, detected at accept:
  - Divisor==0: quotient=0xFFFFFFFF for both DIV and DIVU; remainder=dividend.
  - Signed DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient=0x80000000, remainder=0.
  - Both go IDLE->FIX->DONE; valid_o in cycle 2.
- Divide path, normal:
  - IDLE->DIV. For signed ops, take absolute values and record the quotient sign (a^b) and remainder sign (a).
  - Radix-2 restoring, one quotient bit per cycle, 5-bit counter from 31 down to 0: 32 cycles (cycles 1-32). Counter==0 -> FIX.
  - FIX (cycle 33): negate quotient/remainder per the recorded signs; select quotient (DIV/DIVU) or remainder (REM/REMU). ->DONE.
  - valid_o rises in cycle 34.
- DONE:
  - valid_o=1; result_o and rd_o are stable.
  - valid_o && ready_i -> IDLE next cycle. The next request can be accepted one cycle after the handshake (no same-cycle re-accept).
  - ready_i low: hold indefinitely.
- flush_i:
  - In any non-IDLE state: next state IDLE, valid_o=0, partial state discarded.
  - In IDLE: blocks acceptance that cycle.
  - Flush wins over ready_i in DONE; the result is dropped.
- result_o/rd_o retain their last value outside DONE; consumers qualify them with valid_o only.
- Reset asserted mid-operation: immediately returns to the reset values above.

Test Plan:
- a=b=0xFFFFFFFF:
  - MUL -> 0x00000001
  - MULH -> 0x00000000
  - MULHU -> 0xFFFFFFFE
  - MULHSU -> 0xFFFFFFFF
  - each with valid_o exactly 2 cycles after accept.
- Signed and unsigned divide:
  - DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - valid_o at cycle 34, busy_o high cycles 1-34.
- Special divide cases:
  - DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both at cycle 2.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, both at cycle 2.
- Backpressure: DIVU 100/7 with ready_i low for 3 cycles after valid_o -> result 14 and rd_o held stable; IDLE the cycle after ready_i=1.
- Flush and illegal op:
  - flush_i pulsed at cycle 10 of a DIV -> valid_o never asserts; ready_o=1 at cycle 11; a following MUL 3*4 returns 12 at +2.
  - valid_i with ALU_ADD -> ignored, ready_o stays 1.
- Asynchronous reset mid-division -> valid_o=0, busy_o=0, ready_o=1 without waiting for a clock edge.
